// File: rtl/aud_play_ctrl.sv
// Playback controller: steps an SRAM read address once per DAC LR period and feeds samples to AudPlayer.
// Optional build macro AUD_PLAY_LOOP_EN adds i_loop to wrap to address 0 instead of finishing.
module aud_play_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [2:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_sram_data,
`ifdef AUD_PLAY_LOOP_EN
  input  logic              i_loop,
`endif
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_player_en,
  output logic              o_done,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dac_q, dac_d;
  logic                en_q, en_d;
  logic                done_q, done_d;
  logic                lr_p0_q, lr_p0_d;
  logic                vld_p1_q, vld_p1_d;
  logic                det_p0;
  logic                loop_en;
  logic [ADDR_W:0]     nxt_addr;

  // One bit wider than the address so an overshoot past the top of memory is still seen.
  function automatic logic [ADDR_W:0] step_addr(input logic [ADDR_W-1:0] addr,
                                                input logic [2:0]        speed);
    step_addr = {1'b0, addr} + (ADDR_W+1)'(speed) + (ADDR_W+1)'(1);
  endfunction

`ifdef AUD_PLAY_LOOP_EN
  assign loop_en = i_loop;
`else
  assign loop_en = 1'b0;
`endif

  assign det_p0   = i_daclrck & ~lr_p0_q;
  assign nxt_addr = step_addr(addr_q, i_speed);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dac_d    = dac_q;
    done_d   = 1'b0;
    lr_p0_d  = i_daclrck;
    vld_p1_d = 1'b0;

    if (i_stop) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      dac_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!i_pause && i_start) begin
            state_d = ST_PLAY;
            addr_d  = '0;
            dac_d   = '0;
          end
        end
        ST_PLAY: begin
          if (i_pause) begin
            state_d = ST_PAUSE;
          end else begin
            vld_p1_d = det_p0;
            // Stage p1: the LR edge seen last cycle latches the sample and advances the address.
            if (vld_p1_q) begin
              dac_d = i_sram_data;
              if (nxt_addr > {1'b0, i_end_addr}) begin
                done_d = 1'b1;
                if (loop_en) begin
                  addr_d = '0;
                end else begin
                  state_d = ST_DONE;
                end
              end else begin
                addr_d = nxt_addr[ADDR_W-1:0];
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!i_pause && i_start) begin
            state_d = ST_PLAY;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge i_bclk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      dac_q    <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      lr_p0_q  <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dac_q    <= dac_d;
      en_q     <= en_d;
      done_q   <= done_d;
      lr_p0_q  <= lr_p0_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  assign o_sram_addr = addr_q;
  assign o_dac_data  = dac_q;
  assign o_player_en = en_q;
  assign o_done      = done_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_aud_play_ctrl.sv
// Bench for aud_play_ctrl: table of play runs plus hand-written pause/stop/reset sequences.
module tb_aud_play_ctrl;
  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start, pause, stop, lr;
  logic [2:0]    speed;
  logic [AW-1:0] end_addr;
  logic [DW-1:0] sram = '0;
  logic [AW-1:0] addr;
  logic [DW-1:0] dac;
  logic          en, done;
  logic [1:0]    st;
`ifdef AUD_PLAY_LOOP_EN
  logic          loop;
`endif

  aud_play_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_bclk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_speed(speed), .i_end_addr(end_addr), .i_daclrck(lr), .i_sram_data(sram),
`ifdef AUD_PLAY_LOOP_EN
    .i_loop(loop),
`endif
    .o_sram_addr(addr), .o_dac_data(dac), .o_player_en(en), .o_done(done), .o_state(st)
  );

  always #5 clk = ~clk;

  // SRAM model: word at address A holds A + 0x100, read data one cycle behind the address.
  always @(posedge clk) sram <= addr[DW-1:0] + 16'h0100;

  typedef struct {
    longint a;
    longint d;
    longint dn;
    longint s;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int spd;
    int ea;
    int n;
  } row_t;
  row_t rows[5];

  int total = 0;
  int bad   = 0;
  int m_addr = 0, m_dac = 0, m_end = 0, m_speed = 0, m_st = 0;
  bit m_loop = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cmd(input bit s, input bit p, input bit t);
    start = s; pause = p; stop = t;
    tick();
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " state"}, st, m_st);
    chk({tag, " en"}, en, (m_st == 1) ? 1 : 0);
    chk({tag, " addr"}, addr, m_addr);
    chk({tag, " dac"}, dac, m_dac);
  endtask

  // One LR period; the model predicts the result and the scoreboard holds it until the DUT updates.
  task automatic lr_edge(input string tag);
    exp_t e;
    int nxt;
    bit fin;
    fin = 1'b0;
    if (m_st == 1) begin
      m_dac = (m_addr + 'h100) & 'hffff;
      nxt = m_addr + m_speed + 1;
      if (nxt > m_end) begin
        fin = 1'b1;
        if (m_loop) m_addr = 0;
        else        m_st = 3;
      end else begin
        m_addr = nxt;
      end
    end
    e.a = m_addr; e.d = m_dac; e.dn = fin; e.s = m_st;
    sb.push_back(e);
    lr = 1'b1;
    tick();
    tick();
    e = sb.pop_front();
    chk({tag, " dac"}, dac, e.d);
    chk({tag, " addr"}, addr, e.a);
    chk({tag, " done"}, done, e.dn);
    chk({tag, " state"}, st, e.s);
    tick();
    if (m_st == 3) begin
      m_st = 0;
      chk({tag, " after-done state"}, st, 0);
      chk({tag, " after-done pulse"}, done, 0);
      chk({tag, " after-done en"}, en, 0);
    end
    tick();
    lr = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rows[0] = '{spd: 0, ea: 3,  n: 4};
    rows[1] = '{spd: 3, ea: 9,  n: 3};
    rows[2] = '{spd: 7, ea: 20, n: 3};
    rows[3] = '{spd: 0, ea: 0,  n: 1};
    rows[4] = '{spd: 1, ea: 4,  n: 3};

    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; lr = 1'b0;
    speed = '0; end_addr = '0;
`ifdef AUD_PLAY_LOOP_EN
    loop = 1'b0;
`endif
    repeat (3) tick();
    check_all("reset");
    chk("reset done", done, 0);
    rst = 1'b0;
    tick();

    for (int r = 0; r < 5; r++) begin
      speed = 3'(rows[r].spd);
      end_addr = AW'(rows[r].ea);
      m_speed = rows[r].spd;
      m_end = rows[r].ea;
      cmd(1, 0, 0);
      m_st = 1; m_addr = 0; m_dac = 0;
      check_all($sformatf("row%0d start", r));
      for (int k = 0; k < rows[r].n; k++) lr_edge($sformatf("row%0d edge%0d", r, k));
      chk($sformatf("row%0d ends idle", r), m_st, 0);
      lr_edge($sformatf("row%0d idle edge", r));
    end

    // Pause for five LR periods, then resume where it left off.
    speed = 3'd0; end_addr = AW'(10); m_speed = 0; m_end = 10;
    cmd(1, 0, 0);
    m_st = 1; m_addr = 0; m_dac = 0;
    lr_edge("p edge0");
    lr_edge("p edge1");
    cmd(0, 1, 0);
    m_st = 2;
    check_all("paused");
    for (int k = 0; k < 5; k++) lr_edge("paused edge");
    cmd(1, 0, 0);
    m_st = 1;
    check_all("resumed");
    lr_edge("resume edge");
    chk("resume sample from addr 2", dac, 16'h0102);

    // Start while playing is ignored; pause beats a coincident start.
    cmd(1, 0, 0);
    check_all("start in play");
    cmd(1, 1, 0);
    m_st = 2;
    check_all("pause over start");
    cmd(1, 0, 0);
    m_st = 1;

    // A pending LR edge coinciding with pause is dropped.
    lr = 1'b1;
    tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    m_st = 2;
    check_all("pend dropped");
    tick();
    lr = 1'b0;
    repeat (4) tick();
    cmd(1, 0, 0);
    m_st = 1;
    lr_edge("after drop edge");

    // Stop and pause together: stop wins.
    cmd(0, 1, 1);
    m_st = 0; m_addr = 0; m_dac = 0;
    check_all("stop+pause");

    // Asynchronous reset between the LR edge and the update cycle.
    cmd(1, 0, 0);
    m_st = 1;
    lr_edge("pre-reset edge");
    lr = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    m_st = 0; m_addr = 0; m_dac = 0;
    check_all("async reset");
    chk("async reset done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    cmd(1, 0, 0);
    m_st = 1;
    repeat (3) tick();
    check_all("no stale sample");
    lr = 1'b0;
    repeat (4) tick();
    lr_edge("fresh edge");

`ifdef AUD_PLAY_LOOP_EN
    cmd(0, 0, 1);
    loop = 1'b1; m_loop = 1'b1;
    end_addr = AW'(1); m_end = 1; speed = 3'd0; m_speed = 0;
    cmd(1, 0, 0);
    m_st = 1; m_addr = 0; m_dac = 0;
    for (int k = 0; k < 4; k++) lr_edge($sformatf("loop edge%0d", k));
    cmd(0, 0, 1);
    loop = 1'b0; m_loop = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
